// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, OVERSAMPLE x baud, centre-sampled
// 8-bit frame with one parity bit; byte and error flags delivered with a one-cycle tick.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter bit ODD_nEVEN  = 1'b1
) (
    input  logic       UART_clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // True when the received parity bit disagrees with the configured parity of the byte.
    function automatic logic parity_mismatch(input logic [7:0] d, input logic p);
        logic expected;
        expected = ODD_nEVEN ? ~^d : ^d;
        return (p != expected);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          armed_q, armed_d;
    logic          pbad_q, pbad_d;
    logic          sync1_q, sync2_q;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge UART_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM and output registers.
    always_ff @(posedge UART_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            armed_q <= 1'b0;
            pbad_q  <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            armed_q <= armed_d;
            pbad_q  <= pbad_d;
            data_q  <= data_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; flags are only touched on the cycle the tick is issued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        armed_d = armed_q;
        pbad_d  = pbad_q;
        data_d  = data_q;
        done_d  = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s) begin
                    state_d = S_START;
                    armed_d = 1'b0;
                end else begin
                    armed_d = armed_q | rx_s;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // A line that is high again at mid start bit was only a glitch.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    pbad_d  = parity_mismatch(shreg_q, rx_s);
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    data_d  = shreg_q;
                    perr_d  = pbad_q;
                    ferr_d  = ~rx_s;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign data_out     = data_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign busy         = busy_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive counterpart of the team's UART transmitter.
- Recovers the 11-bit frame from the serial line: start bit (0), 8 data bits LSB first, one parity bit, stop bit (1).
- Oversamples the line at OVERSAMPLE × baud on UART_clk and samples each bit at its centre.
- Delivers each byte with a one-cycle done pulse, plus per-frame parity and framing error flags, to the wrapper/host logic.

Parameters:
- OVERSAMPLE, 16, UART_clk cycles per bit (N). Even, ≥4. Counter width = clog2(N).
- ODD_nEVEN, 1, 1 = odd parity (expected bit = ~^data), 0 = even parity (expected bit = ^data). Must match the transmitter.

Ports:
- UART_clk  in  1  sole clock; N × baud rate
- rst  in  1  asynchronous, active-high reset
- rx  in  1  serial line, asynchronous to UART_clk, idle high
- data_out  out  8  last received byte
- rx_done_tick  out  1  one-cycle pulse: frame complete, outputs updated
- parity_err  out  1  parity mismatch in the last frame
- frame_err  out  1  stop bit sampled as 0 in the last frame
- busy  out  1  high while in any state other than IDLE

Behaviour:
- Reset, asynchronous while rst=1:
  - state=IDLE; data_out=0; rx_done_tick=0; parity_err=0; frame_err=0; busy=0.
  - Synchronizer flops = 1; counters and shift register = 0; armed = 0.
- Input path:
  - 2-flop synchronizer on rx produces rx_s.
  - All decisions use rx_s only. Raw rx is never used.
- States: IDLE, START, DATA, PARITY, STOP. The sample counter cnt increments every cycle in non-IDLE states. H = N/2.
- IDLE:
  - armed sets on any cycle where rx_s=1.
  - If armed and rx_s=0: go to START, cnt=0, clear armed. Call this entry cycle T0.
- START:
  - At cnt=H-1, sample rx_s.
  - rx_s=0: go to DATA, cnt=0, bit index=0.
  - rx_s=1: false start (glitch). Go to IDLE with no pulse and no flag change.
- DATA:
  - At cnt=N-1, shift rx_s into bit 7 of the shift register (right shift, so the first bit lands at bit 0) and clear cnt.
  - After the 8th sample, go to PARITY.
  - Data bit i is sampled at T0+H-1+(i+1)N.
- PARITY:
  - At cnt=N-1 (T0+H-1+9N), latch parity_bad = (rx_s != expected parity of the shift register).
  - Go to STOP with cnt=0.
- STOP:
  - At cnt=N-1 (T0+H-1+10N), sample the stop bit and return to IDLE.
  - On the next edge (T0+H+10N), registered outputs update together:
    - data_out = shift register
    - parity_err = parity_bad
    - frame_err = ~rx_s
    - rx_done_tick = 1 for exactly one cycle
  - The byte is delivered even when either error flag is set.
- Error flags:
  - Both flags hold their value until the next rx_done_tick.
  - They are never cleared by anything else except reset.
- Re-arm:
  - IDLE requires rx_s=1 before accepting a new start.
  - A frame error or break (line held low) therefore produces exactly one frame and no further frames until the line returns high.
  - A normal stop bit re-arms within the remaining half stop bit, so back-to-back frames with no idle gap are received.
- busy = (state != IDLE). Registered; no combinational input-to-output paths.
- Reset mid-frame: abort immediately and return to reset values. No tick for the partial frame. A re-arm is needed after release.
- Data bits are single-sampled at bit centre; there is no majority vote.

Test Plan:
- Nominal, N=16, odd parity: send 0xA5 with parity 1 and stop 1 -> one rx_done_tick at T0+8+160 cycles; data_out=0xA5; parity_err=0; frame_err=0; busy low after the tick.
- Parity error: send 0x3C with parity bit 0 (expected 1) -> tick; data_out=0x3C; parity_err=1; frame_err=0. Next a good frame 0x01 with parity 0 -> parity_err returns to 0.
- Framing error/break: send 0x55 with stop bit 0, then hold rx low for 40 bit times -> exactly one tick, frame_err=1, data_out=0x55. No further ticks until rx goes high and a new valid frame arrives.
- Glitch rejection: rx low for 3 cycles, then high -> no tick, busy returns to 0 within 8 cycles, flags unchanged.
- Back-to-back: frames 0x00 then 0xFF with no idle gap -> two ticks exactly 11N cycles apart; data_out 0x00 then 0xFF; no errors.
- Reset mid-frame: assert rst during bit 4 of a frame -> outputs return to reset values at once, no tick. ODD_nEVEN=0 rerun: 0xA5 with parity 0 -> no parity_err.
